// File: rtl/oam_dma_engine.sv
// oam_dma_engine
// Executes the OAM DMA transfer launched by a CPU write to 0xFF46: copies
// LENGTH bytes from page src (echo RAM folded down) to DEST_BASE, four
// cycles per byte, owning the memory port through a bus_req/bus_gnt handshake.
// A grant lost mid-byte lets the current byte finish, then the engine waits
// in REQ and resumes at the same index.
// Optional build macro DMA_RESTART_EN: a dma_start while busy restarts the
// transfer from index 0 with the new source page.
//
// state   | meaning
// IDLE    | waiting for dma_start
// REQ     | bus_req high, waiting for bus_gnt
// RD_ADDR | source address + mem_oe presented, memory registers address
// RD_DATA | address held, read data captured at end of cycle
// WR_ADDR | destination address + write data presented
// WR_DATA | mem_we high, index advances at end of cycle
// DONE    | one-cycle done pulse, bus released
module oam_dma_engine #(
  parameter int          LENGTH    = 160,
  parameter logic [15:0] DEST_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_start,
  input  logic [7:0]  dma_src_hi,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] mem_address,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done
);

  localparam int IDX_W = $clog2(LENGTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    WR_ADDR = 3'd4,
    WR_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       src_q, src_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  // Remembers a grant drop seen at any point inside the current byte.
  logic             lost_q, lost_d;

  logic             in_xfer;
  logic             restart;
  logic [7:0]       src_mapped;
  logic [7:0]       idx_lo;
  logic [15:0]      dest_addr;

  // Echo RAM E000-FFFF mirrors C000-DFFF.
  assign src_mapped = (dma_src_hi >= 8'hE0) ? (dma_src_hi - 8'h20) : dma_src_hi;
  assign in_xfer    = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                      (state_q == WR_ADDR) || (state_q == WR_DATA);
  assign idx_lo     = 8'(idx_q);
  assign dest_addr  = DEST_BASE + 16'(idx_q);

`ifdef DMA_RESTART_EN
  assign restart = dma_start && (state_q != IDLE) && (state_q != DONE);
`else
  assign restart = 1'b0;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= 8'h00;
      idx_q   <= '0;
      byte_q  <= 8'h00;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      lost_q  <= lost_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    lost_d  = lost_q;

    if (in_xfer && !bus_gnt) begin
      lost_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (dma_start) begin
          src_d   = src_mapped;
          idx_d   = '0;
          lost_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          lost_d  = 1'b0;
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        byte_d  = mem_rdata;
        state_d = WR_ADDR;
      end
      WR_ADDR: state_d = WR_DATA;
      WR_DATA: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else if (lost_q || !bus_gnt) begin
          state_d = REQ;
        end else begin
          state_d = RD_ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Restart wins over normal sequencing; the WR_DATA write of this cycle
    // has already been presented and still lands in memory.
    if (restart) begin
      src_d = src_mapped;
      idx_d = '0;
      if (in_xfer && bus_gnt && !lost_q) begin
        state_d = RD_ADDR;
      end else begin
        state_d = REQ;
      end
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus_req     = 1'b0;
    mem_address = 16'h0000;
    mem_oe      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = 8'h00;
    busy        = (state_q != IDLE);
    done        = 1'b0;

    case (state_q)
      REQ: bus_req = 1'b1;
      RD_ADDR, RD_DATA: begin
        bus_req     = 1'b1;
        mem_address = {src_q, idx_lo};
        mem_oe      = 1'b1;
      end
      WR_ADDR: begin
        bus_req     = 1'b1;
        mem_address = dest_addr;
        mem_wdata   = byte_q;
      end
      WR_DATA: begin
        bus_req     = 1'b1;
        mem_address = dest_addr;
        mem_wdata   = byte_q;
        mem_we      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine with a 64 KiB memory model (1-cycle read
// latency) and an in-order write scoreboard.
module tb_oam_dma_engine;

  logic        clk;
  logic        rst;
  logic        dma_start;
  logic [7:0]  dma_src_hi;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] mem_address;
  logic        mem_oe;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;

  oam_dma_engine dut (
    .clk         (clk),
    .rst         (rst),
    .dma_start   (dma_start),
    .dma_src_hi  (dma_src_hi),
    .bus_req     (bus_req),
    .bus_gnt     (bus_gnt),
    .mem_address (mem_address),
    .mem_oe      (mem_oe),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source page contents, distinct per page.
  function automatic logic [7:0] pval(input logic [7:0] page, input logic [7:0] i);
    case (page)
      8'hC0:   pval = i ^ 8'h5A;
      8'hC1:   pval = i ^ 8'hA5;
      8'hD1:   pval = i ^ 8'h3C;
      default: pval = 8'h00;
    endcase
  endfunction

  logic [7:0] mem [0:65535];
  logic       mem_init;
  logic       mem_clr;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 256; j++) begin
        mem[{8'hC0, 8'(j)}] <= pval(8'hC0, 8'(j));
        mem[{8'hC1, 8'(j)}] <= pval(8'hC1, 8'(j));
        mem[{8'hD1, 8'(j)}] <= pval(8'hD1, 8'(j));
      end
    end else if (mem_clr) begin
      for (int j = 0; j < 256; j++) mem[{8'hFE, 8'(j)}] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_address] <= mem_wdata;
    end
    if (mem_oe) mem_rdata <= mem[mem_address];
  end

  int n_cmp = 0;
  int n_err = 0;
  int wr_pos;
  int wr_cnt;
  int done_cnt = 0;
  logic [7:0] exp_page;
  logic [7:0] exp_rd_page;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge, run the protocol and write checks.
  task automatic step();
    @(negedge clk);
    check_eq("oe_we_excl", 32'(mem_oe & mem_we), 0);
    if (mem_oe) check_eq("rd_page", 32'(mem_address[15:8]), 32'(exp_rd_page));
    if (mem_we) begin
      check_eq("wr_addr", 32'(mem_address), 32'h0000FE00 + wr_pos);
      check_eq("wr_data", 32'(mem_wdata), 32'(pval(exp_page, 8'(wr_pos))));
      wr_pos++;
      wr_cnt++;
    end
    if (done) done_cnt++;
  endtask

  task automatic clear_oam();
    mem_clr = 1'b1;
    step();
    mem_clr = 1'b0;
  endtask

  task automatic start_dma(input logic [7:0] src, input logic [7:0] page);
    exp_page    = page;
    exp_rd_page = page;
    wr_pos      = 0;
    wr_cnt      = 0;
    dma_src_hi  = src;
    dma_start   = 1'b1;
    step();
    dma_start   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 2000) begin
      step();
      n++;
    end
    if (!done) check_eq("done_timeout", 0, 1);
    step();
    check_eq("busy_after_done", 32'(busy), 0);
  endtask

  task automatic verify_oam(input logic [7:0] page);
    for (int i = 0; i < 160; i++)
      check_eq("oam", 32'(mem[16'hFE00 + i]), 32'(pval(page, 8'(i))));
  endtask

  task automatic wait_addr(input logic [15:0] addr, input logic want_we);
    int n;
    n = 0;
    while (!((want_we ? mem_we : mem_oe) && mem_address == addr) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check_eq("addr_timeout", 32'(addr), 0);
  endtask

  initial begin
    int n;
    int dc;
    rst         = 1'b1;
    dma_start   = 1'b0;
    dma_src_hi  = 8'h00;
    bus_gnt     = 1'b1;
    mem_init    = 1'b0;
    mem_clr     = 1'b0;
    exp_page    = 8'hC0;
    exp_rd_page = 8'hC0;
    wr_pos      = 0;
    wr_cnt      = 0;
    mem_init    = 1'b1;
    step();
    mem_init    = 1'b0;
    step();

    // Reset state
    check_eq("rst_bus_req", 32'(bus_req), 0);
    check_eq("rst_oe", 32'(mem_oe), 0);
    check_eq("rst_we", 32'(mem_we), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_addr", 32'(mem_address), 0);
    check_eq("rst_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;
    clear_oam();

    // Basic copy from C0 with grant held; done timing from REQ entry
    start_dma(8'hC0, 8'hC0);
    check_eq("req_entry_bus_req", 32'(bus_req), 1);
    check_eq("req_entry_busy", 32'(busy), 1);
    dc = done_cnt;
    n = 0;
    while (!done && n < 1000) begin
      step();
      n++;
    end
    check_eq("done_cycle", n, 641);
    check_eq("busy_during_done", 32'(busy), 1);
    step();
    n++;
    check_eq("done_width", 32'(done), 0);
    check_eq("busy_fall_cycle", 32'(busy), 0);
    check_eq("busy_fall_n", n, 642);
    check_eq("c0_wr_cnt", wr_cnt, 160);
    check_eq("c0_done_cnt", done_cnt - dc, 1);
    verify_oam(8'hC0);

    // Echo remap: F1 reads from D1
    clear_oam();
    start_dma(8'hF1, 8'hD1);
    wait_done();
    check_eq("f1_wr_cnt", wr_cnt, 160);
    verify_oam(8'hD1);

    // Grant withheld 10 cycles
    clear_oam();
    bus_gnt = 1'b0;
    start_dma(8'hC1, 8'hC1);
    for (int i = 0; i < 10; i++) begin
      check_eq("wait_bus_req", 32'(bus_req), 1);
      check_eq("wait_oe", 32'(mem_oe), 0);
      check_eq("wait_we", 32'(mem_we), 0);
      step();
    end
    bus_gnt = 1'b1;
    step();
    check_eq("gnt_first_oe", 32'(mem_oe), 1);
    check_eq("gnt_first_addr", 32'(mem_address), 32'h0000C100);
    wait_done();
    check_eq("gnt_wr_cnt", wr_cnt, 160);
    verify_oam(8'hC1);

    // Grant dropped during byte 37 read-data for 5 cycles
    clear_oam();
    start_dma(8'hC0, 8'hC0);
    wait_addr(16'hC025, 1'b0);
    step();
    check_eq("drop_rd_data_addr", 32'(mem_address), 32'h0000C025);
    bus_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("drop_bus_req", 32'(bus_req), 1);
    end
    check_eq("drop_wr_pos", wr_pos, 38);
    bus_gnt = 1'b1;
    step();
    check_eq("resume_oe", 32'(mem_oe), 1);
    check_eq("resume_addr", 32'(mem_address), 32'h0000C026);
    wait_done();
    check_eq("drop_wr_cnt", wr_cnt, 160);
    verify_oam(8'hC0);

    // Second start at byte 50's write
    clear_oam();
    start_dma(8'hC0, 8'hC0);
    wait_addr(16'hFE32, 1'b1);
    step();
    dma_src_hi = 8'hC1;
    dma_start  = 1'b1;
`ifdef DMA_RESTART_EN
    exp_page    = 8'hC1;
    exp_rd_page = 8'hC1;
    wr_pos      = 0;
`endif
    step();
    dma_start = 1'b0;
    wait_done();
`ifdef DMA_RESTART_EN
    check_eq("restart_wr_cnt", wr_cnt, 211);
    verify_oam(8'hC1);
`else
    check_eq("restart_wr_cnt", wr_cnt, 160);
    verify_oam(8'hC0);
`endif

    // Reset asserted at byte 80
    clear_oam();
    start_dma(8'hC0, 8'hC0);
    wait_addr(16'hFE50, 1'b1);
    dc = done_cnt;
    rst = 1'b1;
    step();
    check_eq("mid_rst_bus_req", 32'(bus_req), 0);
    check_eq("mid_rst_oe", 32'(mem_oe), 0);
    check_eq("mid_rst_we", 32'(mem_we), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_done", 32'(done), 0);
    check_eq("mid_rst_addr", 32'(mem_address), 0);
    check_eq("mid_rst_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("mid_rst_no_done", done_cnt - dc, 0);
    check_eq("mid_rst_idle_busy", 32'(busy), 0);
    clear_oam();
    start_dma(8'hC1, 8'hC1);
    wait_done();
    check_eq("post_rst_wr_cnt", wr_cnt, 160);
    verify_oam(8'hC1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
